// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, requester
// limits, system clock/baud constants and a small width helper.
package uart_tx_arbiter_pkg;

    // Upper bound on requesters the round-robin selector is built for.
    localparam int NUM_REQ_MAX = 8;

    // System-wide UART timing constants shared with the serializer.
    localparam int CLK_FREQ_HZ  = 50_000_000;
    localparam int BAUD_RATE    = 115_200;
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin selector: the first asserted request found when
// scanning from ptr+1 upward (wrapping modulo NUM_REQ) wins.
module uart_tx_arbiter_rr_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   winner
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    localparam int SUM_W = IDX_W + 1;

    logic [NUM_REQ-1:0] rot_req;
    logic [IDX_W-1:0]   rot_idx [NUM_REQ];

    // Position gi of the rotated view holds requester (ptr + 1 + gi) mod NUM_REQ.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [SUM_W-1:0] sum;
            assign sum         = SUM_W'(ptr) + SUM_W'(gi + 1);
            assign rot_idx[gi] = (sum >= SUM_W'(NUM_REQ)) ? IDX_W'(sum - SUM_W'(NUM_REQ))
                                                          : IDX_W'(sum);
            assign rot_req[gi] = req[rot_idx[gi]];
        end
    endgenerate

    // Lowest rotated position wins; scanning downward lets it overwrite the rest.
    always_comb begin
        any    = |req;
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                winner = rot_idx[i];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte-stream
// requesters. A grant may carry a burst of up to MAX_BURST bytes; each byte is
// launched with a one-cycle registered start pulse and the arbiter follows
// tx_busy to the end of the frame. A serializer that never raises busy sets a
// sticky error and the grant is released.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int IDX_W         = $clog2(NUM_REQ),
    parameter int MAX_BURST     = 16,
    parameter int START_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 tx_err
);

    localparam int BCNT_W = cnt_width(MAX_BURST);
    localparam int TMO_W  = cnt_width(START_TIMEOUT);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [BCNT_W-1:0]    burst_cnt_q, burst_cnt_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 last_flag_q, last_flag_d;
    logic                 tx_err_q, tx_err_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;

    logic                 rr_any;
    logic [IDX_W-1:0]     rr_winner;
    logic [7:0]           req_bytes [NUM_REQ];
    logic [TMO_W-1:0]     tmo_inc;
    logic                 burst_continue;

    // Unpack the flat data bus into one byte per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign req_bytes[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    uart_tx_arbiter_rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .req    (req),
        .ptr    (ptr_q),
        .any    (rr_any),
        .winner (rr_winner)
    );

    assign tmo_inc = tmo_q + TMO_W'(1);

    // Owner keeps the transmitter only while it still has a non-final byte
    // pending and the burst budget is not used up.
    assign burst_continue = req[grant_idx_q] & ~last_flag_q
                          & (burst_cnt_q < BCNT_W'(MAX_BURST));

    // Next-state and registered-output logic of the arbitration FSM.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        burst_cnt_d   = burst_cnt_q;
        tmo_d         = tmo_q;
        last_flag_d   = last_flag_q;
        tx_err_d      = tx_err_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        req_ack_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    grant_idx_d   = rr_winner;
                    grant_valid_d = 1'b1;
                    burst_cnt_d   = '0;
                    state_d       = ST_SEND;
                end
            end

            ST_SEND: begin
                tx_start_d  = 1'b1;
                tx_data_d   = req_bytes[grant_idx_q];
                req_ack_d   = NUM_REQ'(1) << grant_idx_q;
                last_flag_d = req_last[grant_idx_q];
                burst_cnt_d = burst_cnt_q + BCNT_W'(1);
                tmo_d       = '0;
                state_d     = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_inc == TMO_W'(START_TIMEOUT)) begin
                    // Serializer never took the byte: drop it, flag, rotate on.
                    tx_err_d      = 1'b1;
                    grant_valid_d = 1'b0;
                    ptr_d         = grant_idx_q;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end

            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (burst_continue) begin
                        state_d = ST_SEND;
                    end else begin
                        grant_valid_d = 1'b0;
                        ptr_d         = grant_idx_q;
                        state_d       = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset puts the pointer on the last
    // requester so index 0 is served first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= IDX_W'(NUM_REQ - 1);
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            burst_cnt_q   <= '0;
            tmo_q         <= '0;
            last_flag_q   <= 1'b0;
            tx_err_q      <= 1'b0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            req_ack_q     <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            burst_cnt_q   <= burst_cnt_d;
            tmo_q         <= tmo_d;
            last_flag_q   <= last_flag_d;
            tx_err_q      <= tx_err_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            req_ack_q     <= req_ack_d;
        end
    end

    assign req_ack     = req_ack_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign tx_err      = tx_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte-queue requester models, a simple
// serializer model driving tx_busy, and a scoreboard of expected
// (grant, byte) pairs checked at every tx_start.
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    logic          clk;
    logic          reset;
    logic [NR-1:0] req;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0] req_last;
    logic [NR-1:0] req_ack;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
    logic          grant_valid;
    logic [1:0]    grant_idx;
    logic          tx_err;

    uart_tx_arbiter #(
        .NUM_REQ       (NR),
        .IDX_W         (2),
        .MAX_BURST     (16),
        .START_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ack     (req_ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .tx_err      (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester byte queues.
    logic [7:0] rq_byte [NR][32];
    logic       rq_last [NR][32];
    int         rq_len  [NR];
    int         rq_pos  [NR];

    // Serializer model state.
    logic ser_en;
    int   busy_len;
    int   busy_left;
    logic start_pend;

    // Scoreboard entries: {grant index, byte}.
    logic [15:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            if (rq_pos[i] < rq_len[i]) begin
                req[i]            = 1'b1;
                req_data[8*i +: 8] = rq_byte[i][rq_pos[i]];
                req_last[i]       = rq_last[i][rq_pos[i]];
            end else begin
                req[i]            = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    // mode 0: every byte last; 1: last only on final byte; 2: never last.
    task automatic load(input int i, input logic [7:0] base, input int n, input int mode);
        for (int k = 0; k < n; k++) begin
            rq_byte[i][k] = 8'(base + k);
            rq_last[i][k] = (mode == 0) ? 1'b1 : ((mode == 1) ? (k == n - 1) : 1'b0);
        end
        rq_len[i] = n;
        rq_pos[i] = 0;
    endtask

    task automatic expect_b(input int idx, input logic [7:0] data);
        sb.push_back({8'(idx), data});
    endtask

    task automatic clear_env();
        sb.delete();
        for (int i = 0; i < NR; i++) begin
            rq_len[i] = 0;
            rq_pos[i] = 0;
        end
        drive_reqs();
    endtask

    // One clock: sample #1 after the edge, model serializer and requesters,
    // check any start against the scoreboard.
    task automatic tick();
        logic [15:0]   e;
        logic [NR-1:0] exp_ack;
        @(posedge clk);
        #1;
        if (reset) begin
            tx_busy    = 1'b0;
            busy_left  = 0;
            start_pend = 1'b0;
        end else begin
            if (start_pend && ser_en) begin
                tx_busy   = 1'b1;
                busy_left = busy_len;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_busy = 1'b0;
            end
            start_pend = tx_start;
        end
        if (tx_start) begin
            $display("tx grant=%0d data=%02h ack=%b", grant_idx, tx_data, req_ack);
            chk("start_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e       = sb.pop_front();
                exp_ack = NR'(1) << e[9:8];
                chk("tx_data", 32'(tx_data), 32'(e[7:0]));
                chk("grant_idx", 32'(grant_idx), 32'(e[15:8]));
                chk("req_ack", 32'(req_ack), 32'(exp_ack));
                chk("grant_valid_at_start", 32'(grant_valid), 1);
            end
        end else begin
            chk("ack_without_start", 32'(req_ack), 0);
        end
        for (int i = 0; i < NR; i++) begin
            if (req_ack[i] && rq_pos[i] < rq_len[i]) rq_pos[i]++;
        end
        drive_reqs();
    endtask

    task automatic wait_start(input string tag, input int budget);
        int n;
        n = 0;
        while (!tx_start && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_start_seen"}, 32'(tx_start), 1);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || grant_valid || tx_busy) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_drained_in_budget"}, 32'(n < budget), 1);
        chk({tag, "_scoreboard_empty"}, 32'(sb.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req        = '0;
        req_data   = '0;
        req_last   = '0;
        tx_busy    = 1'b0;
        ser_en     = 1'b1;
        busy_len   = 10;
        busy_left  = 0;
        start_pend = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rq_len[i] = 0;
            rq_pos[i] = 0;
        end
        tick();
        tick();

        // Reset values.
        chk("rst_req_ack", 32'(req_ack), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_grant_valid", 32'(grant_valid), 0);
        chk("rst_grant_idx", 32'(grant_idx), 0);
        chk("rst_tx_err", 32'(tx_err), 0);
        reset = 1'b0;

        // 1: single requester 2, latency and frame tracking.
        busy_len = 10;
        load(2, 8'hA5, 1, 0);
        expect_b(2, 8'hA5);
        drive_reqs();
        tick();
        chk("t1_grant_valid_c1", 32'(grant_valid), 1);
        chk("t1_grant_idx_c1", 32'(grant_idx), 2);
        chk("t1_no_start_c1", 32'(tx_start), 0);
        tick();
        chk("t1_start_c2", 32'(tx_start), 1);
        chk("t1_data_c2", 32'(tx_data), 32'h A5);
        chk("t1_ack_c2", 32'(req_ack), 32'b0100);
        tick();
        chk("t1_start_one_cycle", 32'(tx_start), 0);
        chk("t1_ack_one_cycle", 32'(req_ack), 0);
        for (int k = 0; k < 5; k++) tick();
        chk("t1_grant_held_while_busy", 32'(grant_valid), 1);
        drain("t1", 40);
        chk("t1_grant_released", 32'(grant_valid), 0);

        // 1b: pointer left at 2, so 3 beats 2.
        busy_len = 3;
        load(2, 8'h22, 1, 0);
        load(3, 8'h33, 1, 0);
        expect_b(3, 8'h33);
        expect_b(2, 8'h22);
        drive_reqs();
        drain("t1b", 60);

        // 2: all four requesting from reset, one byte per grant.
        reset = 1'b1;
        tick();
        tick();
        clear_env();
        reset = 1'b0;
        load(0, 8'h10, 2, 0);
        load(1, 8'h21, 1, 0);
        load(2, 8'h32, 1, 0);
        load(3, 8'h43, 1, 0);
        expect_b(0, 8'h10);
        expect_b(1, 8'h21);
        expect_b(2, 8'h32);
        expect_b(3, 8'h43);
        expect_b(0, 8'h11);
        drive_reqs();
        drain("t2", 120);

        // 3: 20-byte burst from 1 is cut at 16 to let 3 in.
        busy_len = 2;
        load(1, 8'h40, 20, 1);
        load(3, 8'h99, 1, 0);
        for (int k = 0; k < 16; k++) expect_b(1, 8'(8'h40 + k));
        expect_b(3, 8'h99);
        for (int k = 16; k < 20; k++) expect_b(1, 8'(8'h40 + k));
        drive_reqs();
        drain("t3", 400);

        // 4: requester 0 drops mid-burst, grant moves to 2.
        reset = 1'b1;
        tick();
        tick();
        clear_env();
        reset = 1'b0;
        busy_len = 3;
        load(0, 8'hA0, 3, 2);
        load(2, 8'hB0, 1, 0);
        expect_b(0, 8'hA0);
        expect_b(0, 8'hA1);
        expect_b(0, 8'hA2);
        expect_b(2, 8'hB0);
        drive_reqs();
        drain("t4", 120);

        // 5: serializer never goes busy -> sticky error after 15 cycles.
        ser_en = 1'b0;
        load(3, 8'h5C, 1, 0);
        load(1, 8'h6D, 1, 0);
        expect_b(3, 8'h5C);
        expect_b(1, 8'h6D);
        drive_reqs();
        wait_start("t5", 10);
        for (int k = 0; k < 14; k++) tick();
        chk("t5_no_err_before_limit", 32'(tx_err), 0);
        chk("t5_grant_held_before_limit", 32'(grant_valid), 1);
        tick();
        chk("t5_err_at_limit", 32'(tx_err), 1);
        chk("t5_grant_released", 32'(grant_valid), 0);
        ser_en = 1'b1;
        drain("t5", 60);
        chk("t5_err_sticky", 32'(tx_err), 1);

        // 6: asynchronous reset during WAIT_DONE.
        busy_len = 10;
        load(2, 8'h77, 1, 0);
        expect_b(2, 8'h77);
        drive_reqs();
        wait_start("t6", 10);
        tick();
        tick();
        tick();
        chk("t6_in_frame", 32'(grant_valid), 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_grant_valid", 32'(grant_valid), 0);
        chk("t6_rst_grant_idx", 32'(grant_idx), 0);
        chk("t6_rst_tx_err", 32'(tx_err), 0);
        chk("t6_rst_tx_start", 32'(tx_start), 0);
        chk("t6_rst_tx_data", 32'(tx_data), 0);
        chk("t6_rst_req_ack", 32'(req_ack), 0);
        tick();
        tick();
        clear_env();
        reset = 1'b0;
        busy_len = 3;
        load(0, 8'h01, 1, 0);
        load(2, 8'h02, 1, 0);
        load(3, 8'h03, 1, 0);
        expect_b(0, 8'h01);
        expect_b(2, 8'h02);
        expect_b(3, 8'h03);
        drive_reqs();
        drain("t6", 120);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
